// File: rtl/axi_ram_excl_pkg.sv
// Shared encodings and helpers for the axi_ram_excl scratch RAM.
package axi_ram_excl_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'b00,
    WR_BURST = 2'b01,
    WR_RESP  = 2'b10
  } wr_state_e;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_e;

  function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_size);
    logic [2:0] res;
    if (size > max_size) begin
      res = max_size;
    end else begin
      res = size;
    end
    return res;
  endfunction

  function automatic logic wrap_len_ok(input logic [7:0] len);
    logic res;
    case (len)
      8'd1, 8'd3, 8'd7, 8'd15: res = 1'b1;
      default:                 res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address generator and decode-range flag for one AXI address channel.
module axi_burst_addr
  import axi_ram_excl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int MEM_ADDR_WIDTH = 14
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  range_err_o
);

  localparam logic [ADDR_WIDTH-1:0] ONE      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] MEM_MASK = (ONE << MEM_ADDR_WIDTH) - ONE;

  logic [ADDR_WIDTH-1:0] incr_s;
  logic [ADDR_WIDTH-1:0] wrap_mask_s;
  logic [ADDR_WIDTH-1:0] seq_addr_s;

  assign incr_s      = ONE << size_i;
  assign seq_addr_s  = addr_i + incr_s;
  assign wrap_mask_s = ((ADDR_WIDTH'(len_i) + ONE) << size_i) - ONE;
  assign range_err_o = |(addr_i & ~MEM_MASK);

  // Illegal WRAP lengths and the reserved encoding fall back to INCR stepping.
  always_comb begin
    next_addr_o = seq_addr_s;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = seq_addr_s;
      BURST_WRAP: begin
        if (wrap_len_ok(len_i)) begin
          next_addr_o = (addr_i & ~wrap_mask_s) | (seq_addr_s & wrap_mask_s);
        end else begin
          next_addr_o = seq_addr_s;
        end
      end
      default:     next_addr_o = seq_addr_s;
    endcase
  end

endmodule

// File: rtl/axi_ram_excl.sv
// AXI4 slave scratch RAM: independent read/write burst engines, per-beat decode
// errors and a single-entry exclusive monitor backing LR/SC.
module axi_ram_excl
  import axi_ram_excl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int MEM_ADDR_WIDTH = 14,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int ID_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int WIDX_W   = MEM_ADDR_WIDTH - ADDR_LSB;
  localparam int MWIDX_W  = ADDR_WIDTH - ADDR_LSB;
  localparam int DEPTH    = 1 << WIDX_W;
  localparam logic [2:0] MAX_SIZE = 3'(ADDR_LSB);
  localparam logic [ADDR_WIDTH-1:0] ONE      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] MEM_MASK = (ONE << MEM_ADDR_WIDTH) - ONE;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  wr_state_e             wr_state_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]            wlen_q, wcnt_q;
  logic [2:0]            wsize_q;
  logic [1:0]            wburst_q;
  logic                  wlock_q, wexcl_ok_q, werr_q;

  rd_state_e             rd_state_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [7:0]            rlen_q, rcnt_q;
  logic [2:0]            rsize_q;
  logic [1:0]            rburst_q;
  logic                  rexcl_q;

  logic                  mon_valid_q;
  logic [ID_WIDTH-1:0]   mon_id_q;
  logic [MWIDX_W-1:0]    mon_widx_q;
  logic [7:0]            mon_len_q;
  logic [2:0]            mon_size_q;

  logic                  aw_hs_s, w_hs_s, w_final_s, ar_hs_s, r_issue_s, r_pop_s;
  logic [ADDR_WIDTH-1:0] waddr_next_s, raddr_next_s;
  logic                  wbeat_err_s, rbeat_err_s, ar_err_s;
  logic [2:0]            awsize_eff_s, arsize_eff_s;
  logic                  excl_match_s, we_s, mon_load_s, mon_clear_s;
  logic [WIDX_W-1:0]     widx_s, ridx_s;
  logic [1:0]            bresp_d, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  unused_s;

  assign unused_s = ^{s_axi_awcache, s_axi_awprot, s_axi_arcache, s_axi_arprot, s_axi_wlast};

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  assign awsize_eff_s = clamp_size(s_axi_awsize, MAX_SIZE);
  assign arsize_eff_s = clamp_size(s_axi_arsize, MAX_SIZE);

  assign aw_hs_s   = s_axi_awvalid && awready_q;
  assign w_hs_s    = s_axi_wvalid && wready_q;
  assign w_final_s = w_hs_s && (wcnt_q == wlen_q);
  assign ar_hs_s   = s_axi_arvalid && arready_q;
  assign r_pop_s   = rvalid_q && s_axi_rready;
  assign r_issue_s = (rd_state_q == RD_BURST) && (!rvalid_q || s_axi_rready);
  assign ar_err_s  = |(s_axi_araddr & ~MEM_MASK);

  axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)) u_wr_addr (
    .addr_i      (waddr_q),
    .len_i       (wlen_q),
    .size_i      (wsize_q),
    .burst_i     (wburst_q),
    .next_addr_o (waddr_next_s),
    .range_err_o (wbeat_err_s)
  );

  axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)) u_rd_addr (
    .addr_i      (raddr_q),
    .len_i       (rlen_q),
    .size_i      (rsize_q),
    .burst_i     (rburst_q),
    .next_addr_o (raddr_next_s),
    .range_err_o (rbeat_err_s)
  );

  // The exclusive decision is taken once at AW acceptance and held for the whole burst.
  assign excl_match_s = mon_valid_q && (s_axi_awid == mon_id_q)
                     && (s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB] == mon_widx_q)
                     && (s_axi_awlen == mon_len_q) && (awsize_eff_s == mon_size_q);

  assign widx_s = waddr_q[MEM_ADDR_WIDTH-1:ADDR_LSB];
  assign ridx_s = raddr_q[MEM_ADDR_WIDTH-1:ADDR_LSB];
  assign we_s   = w_hs_s && !wbeat_err_s && !(wlock_q && !wexcl_ok_q);

  assign mon_load_s  = ar_hs_s && s_axi_arlock && !ar_err_s;
  assign mon_clear_s = (we_s && (waddr_q[ADDR_WIDTH-1:ADDR_LSB] == mon_widx_q))
                    || (w_final_s && wlock_q && wexcl_ok_q);

  assign rdata_d = rbeat_err_s ? {DATA_WIDTH{1'b0}} : mem[ridx_s];

  // Write response: decode errors dominate, then the exclusive outcome.
  always_comb begin
    if (werr_q || wbeat_err_s) begin
      bresp_d = RESP_DECERR;
    end else if (wlock_q && wexcl_ok_q) begin
      bresp_d = RESP_EXOKAY;
    end else begin
      bresp_d = RESP_OKAY;
    end
  end

  // Per-beat read response.
  always_comb begin
    if (rbeat_err_s) begin
      rresp_d = RESP_DECERR;
    end else if (rexcl_q) begin
      rresp_d = RESP_EXOKAY;
    end else begin
      rresp_d = RESP_OKAY;
    end
  end

  // Storage is deliberately left unreset; only strobed lanes of accepted beats land.
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) begin
          mem[widx_s][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  // Write channel FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= {ID_WIDTH{1'b0}};
      bresp_q    <= RESP_OKAY;
      waddr_q    <= {ADDR_WIDTH{1'b0}};
      wlen_q     <= 8'd0;
      wcnt_q     <= 8'd0;
      wsize_q    <= 3'd0;
      wburst_q   <= BURST_INCR;
      wlock_q    <= 1'b0;
      wexcl_ok_q <= 1'b0;
      werr_q     <= 1'b0;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          awready_q <= 1'b1;
          if (aw_hs_s) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            bid_q      <= s_axi_awid;
            waddr_q    <= s_axi_awaddr;
            wlen_q     <= s_axi_awlen;
            wcnt_q     <= 8'd0;
            wsize_q    <= awsize_eff_s;
            wburst_q   <= s_axi_awburst;
            wlock_q    <= s_axi_awlock;
            wexcl_ok_q <= s_axi_awlock && excl_match_s;
            werr_q     <= 1'b0;
            wr_state_q <= WR_BURST;
          end
        end
        WR_BURST: begin
          if (w_hs_s) begin
            waddr_q <= waddr_next_s;
            wcnt_q  <= wcnt_q + 8'd1;
            werr_q  <= werr_q | wbeat_err_s;
            if (w_final_s) begin
              wready_q   <= 1'b0;
              bvalid_q   <= 1'b1;
              bresp_q    <= bresp_d;
              wr_state_q <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wr_state_q <= WR_IDLE;
          end
        end
        default: begin
          wready_q   <= 1'b0;
          bvalid_q   <= 1'b0;
          wr_state_q <= WR_IDLE;
        end
      endcase
    end
  end

  // Read channel FSM; a beat issues whenever the R register is empty or draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= {ID_WIDTH{1'b0}};
      rdata_q    <= {DATA_WIDTH{1'b0}};
      rresp_q    <= RESP_OKAY;
      raddr_q    <= {ADDR_WIDTH{1'b0}};
      rlen_q     <= 8'd0;
      rcnt_q     <= 8'd0;
      rsize_q    <= 3'd0;
      rburst_q   <= BURST_INCR;
      rexcl_q    <= 1'b0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          arready_q <= 1'b1;
          if (r_pop_s) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
          end
          if (ar_hs_s) begin
            arready_q  <= 1'b0;
            rid_q      <= s_axi_arid;
            raddr_q    <= s_axi_araddr;
            rlen_q     <= s_axi_arlen;
            rcnt_q     <= 8'd0;
            rsize_q    <= arsize_eff_s;
            rburst_q   <= s_axi_arburst;
            rexcl_q    <= s_axi_arlock && !ar_err_s;
            rd_state_q <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (r_issue_s) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= (rcnt_q == rlen_q);
            raddr_q  <= raddr_next_s;
            rcnt_q   <= rcnt_q + 8'd1;
            if (rcnt_q == rlen_q) begin
              arready_q  <= 1'b1;
              rd_state_q <= RD_IDLE;
            end
          end
        end
        default: begin
          rvalid_q   <= 1'b0;
          rd_state_q <= RD_IDLE;
        end
      endcase
    end
  end

  // Exclusive monitor; a load in the same cycle as a clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_valid_q <= 1'b0;
      mon_id_q    <= {ID_WIDTH{1'b0}};
      mon_widx_q  <= {MWIDX_W{1'b0}};
      mon_len_q   <= 8'd0;
      mon_size_q  <= 3'd0;
    end else begin
      if (mon_load_s) begin
        mon_valid_q <= 1'b1;
        mon_id_q    <= s_axi_arid;
        mon_widx_q  <= s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];
        mon_len_q   <= s_axi_arlen;
        mon_size_q  <= arsize_eff_s;
      end else if (mon_clear_s) begin
        mon_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_ram_excl.sv
// Directed self-checking bench for axi_ram_excl with hand-computed expectations.
module tb_axi_ram_excl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [15:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic        s_axi_awlock, s_axi_arlock, s_axi_awvalid, s_axi_arvalid;
  logic [3:0]  s_axi_awcache, s_axi_arcache, s_axi_wstrb;
  logic        s_axi_awready, s_axi_arready, s_axi_wready, s_axi_wlast, s_axi_wvalid;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic        s_axi_bvalid, s_axi_bready, s_axi_rlast, s_axi_rvalid, s_axi_rready;

  int errors = 0;
  int checks = 0;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  int          nbeats;
  logic [1:0]  bresp_got;
  logic        toggle_rready = 1'b0;

  axi_ram_excl dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic lock);
    int t;
    @(negedge clk);
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size;
    s_axi_awburst = burst; s_axi_awlock = lock; s_axi_awvalid = 1'b1;
    t = 0;
    while (!s_axi_awready && t < 100) begin @(negedge clk); t++; end
    check_eq("aw_wait", s_axi_awready, 1'b1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wdata = wd[i]; s_axi_wstrb = ws[i]; s_axi_wlast = (i == int'(len)); s_axi_wvalid = 1'b1;
      t = 0;
      while (!s_axi_wready && t < 100) begin @(negedge clk); t++; end
      check_eq("w_wait", s_axi_wready, 1'b1);
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check_eq("b_latency", s_axi_bvalid, 1'b1);
    s_axi_bready = 1'b1;
    t = 0;
    while (!s_axi_bvalid && t < 100) begin @(negedge clk); t++; end
    bresp_got = s_axi_bresp;
    check_eq("bid", s_axi_bid, id);
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic lock);
    int t;
    @(negedge clk);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size;
    s_axi_arburst = burst; s_axi_arlock = lock; s_axi_arvalid = 1'b1;
    t = 0;
    while (!s_axi_arready && t < 100) begin @(negedge clk); t++; end
    check_eq("ar_wait", s_axi_arready, 1'b1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    nbeats = 0;
    t = 0;
    while (nbeats <= int'(len) && t < 200) begin
      s_axi_rready = toggle_rready ? (t % 2 == 1) : 1'b1;
      if (s_axi_rvalid && s_axi_rready) begin
        if (nbeats == 0) check_eq("rid", s_axi_rid, id);
        rd_data[nbeats] = s_axi_rdata;
        rd_resp[nbeats] = s_axi_rresp;
        rd_last[nbeats] = s_axi_rlast;
        nbeats++;
      end
      @(negedge clk);
      t++;
    end
    s_axi_rready = 1'b0;
    check_eq("r_beats", nbeats, int'(len) + 1);
    check_eq("r_drain", s_axi_rvalid, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_w [8];
    s_axi_awid = 8'd0; s_axi_awaddr = 16'd0; s_axi_awlen = 8'd0; s_axi_awsize = 3'd0;
    s_axi_awburst = 2'd0; s_axi_awlock = 1'b0; s_axi_awcache = 4'd0; s_axi_awprot = 3'd0;
    s_axi_awvalid = 1'b0; s_axi_wdata = 32'd0; s_axi_wstrb = 4'd0; s_axi_wlast = 1'b0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = 8'd0; s_axi_araddr = 16'd0; s_axi_arlen = 8'd0; s_axi_arsize = 3'd0;
    s_axi_arburst = 2'd0; s_axi_arlock = 1'b0; s_axi_arcache = 4'd0; s_axi_arprot = 3'd0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_awready", s_axi_awready, 1'b0);
    check_eq("rst_arready", s_axi_arready, 1'b0);
    check_eq("rst_wready", s_axi_wready, 1'b0);
    check_eq("rst_bvalid", s_axi_bvalid, 1'b0);
    check_eq("rst_rvalid", s_axi_rvalid, 1'b0);
    check_eq("rst_rlast", s_axi_rlast, 1'b0);
    check_eq("rst_rdata", s_axi_rdata, 32'd0);
    check_eq("rst_ids", {s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp}, 20'd0);
    rst = 1'b0;
    #1 check_eq("awready_pre_edge", s_axi_awready, 1'b0);
    @(negedge clk);
    check_eq("awready_post", s_axi_awready, 1'b1);
    check_eq("arready_post", s_axi_arready, 1'b1);

    // INCR write then read
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h11 * (i + 1); ws[i] = 4'hF; end
    do_write(8'd1, 16'h0010, 8'd3, 3'd2, 2'b01, 1'b0);
    check_eq("incr_bresp", bresp_got, 2'b00);
    do_read(8'd1, 16'h0010, 8'd3, 3'd2, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("incr_d%0d", i), rd_data[i], 32'h11 * (i + 1));
      check_eq($sformatf("incr_resp%0d", i), rd_resp[i], 2'b00);
      check_eq($sformatf("incr_last%0d", i), rd_last[i], (i == 3));
    end

    // Oversized beat clamps to the 4-byte bus
    do_read(8'd4, 16'h0010, 8'd1, 3'd3, 2'b01, 1'b0);
    check_eq("clamp_d0", rd_data[0], 32'h11);
    check_eq("clamp_d1", rd_data[1], 32'h22);

    // WRAP read: beats at 0x38, 0x3C, 0x30, 0x34
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
    do_write(8'd1, 16'h0030, 8'd3, 3'd2, 2'b01, 1'b0);
    do_read(8'd2, 16'h0038, 8'd3, 3'd2, 2'b10, 1'b0);
    check_eq("wrap_d0", rd_data[0], 32'hA2);
    check_eq("wrap_d1", rd_data[1], 32'hA3);
    check_eq("wrap_d2", rd_data[2], 32'hA0);
    check_eq("wrap_d3", rd_data[3], 32'hA1);

    // Narrow FIXED write into byte lane 2
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(8'd1, 16'h0100, 8'd0, 3'd2, 2'b01, 1'b0);
    wd[0] = 32'h00AB0000; ws[0] = 4'b0100;
    wd[1] = 32'h00CD0000; ws[1] = 4'b0100;
    do_write(8'd1, 16'h0102, 8'd1, 3'd0, 2'b00, 1'b0);
    check_eq("fixed_bresp", bresp_got, 2'b00);
    do_read(8'd1, 16'h0100, 8'd0, 3'd2, 2'b01, 1'b0);
    check_eq("fixed_word", rd_data[0], 32'h11CD3344);

    // Out of range
    wd[0] = 32'h5A5A5A5A; ws[0] = 4'hF;
    do_write(8'd1, 16'h0000, 8'd0, 3'd2, 2'b01, 1'b0);
    do_read(8'd1, 16'h4000, 8'd0, 3'd2, 2'b01, 1'b0);
    check_eq("oor_rdata", rd_data[0], 32'd0);
    check_eq("oor_rresp", rd_resp[0], 2'b11);
    wd[0] = 32'hDEADBEEF;
    do_write(8'd1, 16'h4000, 8'd0, 3'd2, 2'b01, 1'b0);
    check_eq("oor_bresp", bresp_got, 2'b11);
    do_read(8'd1, 16'h0000, 8'd0, 3'd2, 2'b01, 1'b0);
    check_eq("oor_alias_kept", rd_data[0], 32'h5A5A5A5A);

    // Exclusive pair succeeds
    wd[0] = 32'h0; ws[0] = 4'hF;
    do_write(8'd1, 16'h0200, 8'd0, 3'd2, 2'b01, 1'b0);
    do_read(8'd5, 16'h0200, 8'd0, 3'd2, 2'b01, 1'b1);
    check_eq("lr_rresp", rd_resp[0], 2'b01);
    wd[0] = 32'hCAFE0001;
    do_write(8'd5, 16'h0200, 8'd0, 3'd2, 2'b01, 1'b1);
    check_eq("sc_bresp", bresp_got, 2'b01);
    do_read(8'd1, 16'h0200, 8'd0, 3'd2, 2'b01, 1'b0);
    check_eq("sc_data", rd_data[0], 32'hCAFE0001);
    check_eq("plain_rresp", rd_resp[0], 2'b00);
    // Monitor was consumed, so a repeat SC fails
    wd[0] = 32'hCAFE0009;
    do_write(8'd5, 16'h0200, 8'd0, 3'd2, 2'b01, 1'b1);
    check_eq("sc_again_bresp", bresp_got, 2'b00);
    // Intervening write from another ID breaks the reservation
    do_read(8'd5, 16'h0200, 8'd0, 3'd2, 2'b01, 1'b1);
    check_eq("lr2_data", rd_data[0], 32'hCAFE0001);
    wd[0] = 32'h22222222;
    do_write(8'd2, 16'h0200, 8'd0, 3'd2, 2'b01, 1'b0);
    check_eq("intervene_bresp", bresp_got, 2'b00);
    wd[0] = 32'hCAFE0002;
    do_write(8'd5, 16'h0200, 8'd0, 3'd2, 2'b01, 1'b1);
    check_eq("sc_fail_bresp", bresp_got, 2'b00);
    do_read(8'd1, 16'h0200, 8'd0, 3'd2, 2'b01, 1'b0);
    check_eq("sc_fail_data", rd_data[0], 32'h22222222);

    // Backpressure on an 8-beat read
    for (int i = 0; i < 8; i++) begin exp_w[i] = 32'hB000_0000 + i * 32'h1011; wd[i] = exp_w[i]; ws[i] = 4'hF; end
    do_write(8'd7, 16'h0300, 8'd7, 3'd2, 2'b01, 1'b0);
    toggle_rready = 1'b1;
    do_read(8'd7, 16'h0300, 8'd7, 3'd2, 2'b01, 1'b0);
    toggle_rready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("bp_d%0d", i), rd_data[i], exp_w[i]);
      check_eq($sformatf("bp_last%0d", i), rd_last[i], (i == 7));
    end

    // Reset mid-burst on both channels
    @(negedge clk);
    s_axi_awid = 8'd3; s_axi_awaddr = 16'h0340; s_axi_awlen = 8'd3; s_axi_awsize = 3'd2;
    s_axi_awburst = 2'b01; s_axi_awlock = 1'b0; s_axi_awvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    check_eq("mid_wready", s_axi_wready, 1'b1);
    s_axi_wdata = 32'h77777777; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(negedge clk);
    s_axi_wvalid = 1'b0;
    s_axi_arid = 8'd6; s_axi_araddr = 16'h0300; s_axi_arlen = 8'd7; s_axi_arsize = 3'd2;
    s_axi_arburst = 2'b01; s_axi_arlock = 1'b0; s_axi_arvalid = 1'b1;
    check_eq("mid_arready", s_axi_arready, 1'b1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    check_eq("r_lat_before", s_axi_rvalid, 1'b0);
    @(negedge clk);
    check_eq("r_lat_first", s_axi_rvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_rvalid", s_axi_rvalid, 1'b0);
    check_eq("mid_rst_wready", s_axi_wready, 1'b0);
    check_eq("mid_rst_bvalid", s_axi_bvalid, 1'b0);
    check_eq("mid_rst_ready", {s_axi_awready, s_axi_arready}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_bvalid", s_axi_bvalid, 1'b0);
    do_read(8'd1, 16'h0340, 8'd0, 3'd2, 2'b01, 1'b0);
    check_eq("partial_beat_kept", rd_data[0], 32'h77777777);
    wd[0] = 32'h13579BDF; wd[1] = 32'h2468ACE0; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(8'd9, 16'h0344, 8'd1, 3'd2, 2'b01, 1'b0);
    check_eq("post_rst_bresp", bresp_got, 2'b00);
    do_read(8'd9, 16'h0344, 8'd1, 3'd2, 2'b01, 1'b0);
    check_eq("post_rst_d0", rd_data[0], 32'h13579BDF);
    check_eq("post_rst_d1", rd_data[1], 32'h2468ACE0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
